// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, default latencies and line geometry for the
// cache-side memory responder and the cache's timeout checks.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WLAT, RLAT, RBURST} state_e;

    localparam int DEF_READ_LATENCY  = 20;
    localparam int DEF_WRITE_LATENCY = 20;
    localparam int DEF_BLOCK_WORDS   = 4;
    localparam int DEF_OFF_W         = $clog2(DEF_BLOCK_WORDS);

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: 2**ADDR_BITS x 32 word store, asynchronous read, synchronous write
module mem_array #(
  parameter int ADDR_BITS     = 10,
  parameter     MEM_INIT_FILE = ""
) (
  input  logic                 Clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [31:0]          rdata_o
);
  logic [31:0] mem_q [2**ADDR_BITS];
  always_ff @(posedge Clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency line-burst read / write-through memory behind the data cache.
// Define MEM_POSTED_WRITE_EN to add a single-entry posted write buffer.
module mem_responder
    import mem_pkg::*;
#(
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
    parameter int BLOCK_WORDS   = DEF_BLOCK_WORDS,
    parameter int ADDR_BITS     = 10,
    parameter     MEM_INIT_FILE = ""
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic        ReadMiss,
    input  logic        MemWriteThrough,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        ReadReady,
    output logic        WriteReady
);

    localparam int CNT_W = $clog2(lat_max(READ_LATENCY, WRITE_LATENCY) + 1);
    localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(BLOCK_WORDS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          mem_rdata;
    logic                 wr_ok, rd_ok, commit;
    logic                 unused_addr;

    assign word_idx    = Address[ADDR_BITS+1:2];
    assign unused_addr = ^{Address[31:ADDR_BITS+2], Address[1:0]};

`ifdef MEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
    logic             pb_q, pb_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;

    // addr_q/wdata_q double as the buffer entry: no new request is accepted while it is full
    always_comb begin
        pb_d   = pb_q;
        pcnt_d = pcnt_q;
        if (pb_q) begin
            if (pcnt_q == CNT_W'(WRITE_LATENCY)) pb_d = 1'b0;
            else pcnt_d = pcnt_q + 1'b1;
        end
        if (state_q == IDLE && MemWriteThrough && !pb_q) begin
            pb_d   = 1'b1;
            pcnt_d = CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pb_q   <= 1'b0;
            pcnt_q <= '0;
        end else begin
            pb_q   <= pb_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign wr_ok  = !pb_q;
    assign rd_ok  = !pb_q;
    assign commit = pb_q && pcnt_q == CNT_W'(WRITE_LATENCY);
`else
    localparam bit POSTED = 1'b0;
    assign wr_ok  = 1'b1;
    assign rd_ok  = 1'b1;
    assign commit = state_q == WLAT && cnt_q == CNT_W'(WRITE_LATENCY);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ReadReady  = 1'b0;
        WriteReady = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemWriteThrough && wr_ok) begin
                    state_d = WLAT;
                    cnt_d   = CNT_W'(1);
                    addr_d  = word_idx;
                    wdata_d = Write_data;
                end else if (ReadMiss && rd_ok) begin
                    state_d = (READ_LATENCY == 1) ? RBURST : RLAT;
                    cnt_d   = CNT_W'(1);
                    beat_d  = '0;
                    addr_d  = word_idx & LINE_MASK;
                end
            end
            WLAT: begin
                WriteReady = POSTED || cnt_q == CNT_W'(WRITE_LATENCY);
                state_d    = WriteReady ? IDLE : WLAT;
                cnt_d      = WriteReady ? cnt_q : cnt_q + 1'b1;
            end
            RLAT: begin
                state_d = (cnt_q == CNT_W'(READ_LATENCY - 1)) ? RBURST : RLAT;
                cnt_d   = cnt_q + 1'b1;
            end
            RBURST: begin
                ReadReady = 1'b1;
                state_d   = (beat_q == OFF_W'(BLOCK_WORDS - 1)) ? IDLE : RBURST;
                beat_d    = beat_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    mem_array #(
        .ADDR_BITS    (ADDR_BITS),
        .MEM_INIT_FILE(MEM_INIT_FILE)
    ) u_array (
        .Clk    (Clk),
        .we_i   (commit && !Rst),
        .waddr_i(addr_q),
        .wdata_i(wdata_q),
        .raddr_i(addr_q + ADDR_BITS'(beat_q)),
        .rdata_o(mem_rdata)
    );

    assign Read_data = ReadReady ? mem_rdata : 32'b0;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized transactions checked against a word-array model with
// cycle-exact latency expectations; follows MEM_POSTED_WRITE_EN when defined.
module tb_mem_responder;

    localparam int RL    = 20;
    localparam int WL    = 20;
    localparam int BW    = 4;
    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;
`ifdef MEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rd_miss, wr_thru;
    logic [31:0] addr, wdata, rdata;
    logic        rd_rdy, wr_rdy;

    always #5 clk = ~clk;

    mem_responder #(
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL),
        .BLOCK_WORDS  (BW),
        .ADDR_BITS    (AB),
        .MEM_INIT_FILE("")
    ) dut (
        .Clk            (clk),
        .Rst            (rst),
        .Address        (addr),
        .ReadMiss       (rd_miss),
        .MemWriteThrough(wr_thru),
        .Write_data     (wdata),
        .Read_data      (rdata),
        .ReadReady      (rd_rdy),
        .WriteReady     (wr_rdy)
    );

    int          cyc = 0;
    int          drain = -100;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] model [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int accept_cycle();
        return (POSTED && cyc <= drain) ? drain + 1 : cyc;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int t0, n;
        t0      = accept_cycle();
        addr    = a;
        wdata   = d;
        wr_thru = 1'b1;
        n = 0;
        do begin
            tick;
            n++;
        end while (!wr_rdy && n < 200);
        chk("wr_ready_cycle", cyc, t0 + (POSTED ? 1 : WL));
        wr_thru = 1'b0;
        model[(a >> 2) % DEPTH] = d;
        if (POSTED) drain = t0 + WL;
        tick;
        chk("wr_ready_pulse", {31'b0, wr_rdy}, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input bit keep);
        int t0, n, base;
        t0      = accept_cycle();
        base    = ((a >> 2) % DEPTH) / BW * BW;
        addr    = a;
        rd_miss = 1'b1;
        n = 0;
        while (!rd_rdy && n < 200) begin
            tick;
            n++;
        end
        chk("rd_first_beat_cycle", cyc, t0 + RL);
        for (int k = 0; k < BW; k++) begin
            chk("rd_ready_beat", {31'b0, rd_rdy}, 1);
            chk("rd_data_beat", rdata, model[base + k]);
            if (k == BW - 1 && !keep) rd_miss = 1'b0;
            tick;
        end
        chk("rd_ready_after", {31'b0, rd_rdy}, 0);
        chk("rd_data_idle", rdata, 0);
    endtask

    initial begin
        int beats;
        logic [31:0] a;
        rst = 1'b1; rd_miss = 1'b0; wr_thru = 1'b0; addr = '0; wdata = '0;
        tick;
        tick;
        rst = 1'b0;
        chk("reset_read_ready", {31'b0, rd_rdy}, 0);
        chk("reset_write_ready", {31'b0, wr_rdy}, 0);
        chk("reset_read_data", rdata, 0);

        for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom);

        do_write(32'h40, 32'hDEADBEEF);
        do_read(32'h44, 1'b0);

        rd_miss = 1'b1;
        do_write(32'h80, 32'hA5A5_0080);
        do_read(32'h80, 1'b0);

        do_write(32'h1000, 32'h12345678);
        do_read(32'h0, 1'b0);

        do_read(32'h20, 1'b1);
        do_read(32'h30, 1'b0);

        addr    = 32'h10;
        rd_miss = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        rst     = 1'b1;
        rd_miss = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("midrst_read_ready", {31'b0, rd_rdy}, 0);
        chk("midrst_write_ready", {31'b0, wr_rdy}, 0);
        chk("midrst_read_data", rdata, 0);
        beats = 0;
        for (int i = 0; i < RL + BW + 5; i++) begin
            tick;
            if (rd_rdy) beats++;
        end
        chk("midrst_no_beat", beats, 0);
        do_read(32'h10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (($urandom % 64) << 2) | ($urandom % 4);
            if ($urandom % 2) do_write(a, $urandom);
            else do_read(a, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
